// File: rtl/tl_pkg.sv
// Shared colour codes and phase-state enum for the multi-approach traffic light controller.
// Defining TL_PED_EN adds the pedestrian WALK phase.
package tl_pkg;

    localparam logic [1:0] C_GREEN  = 2'b00;
    localparam logic [1:0] C_YELLOW = 2'b01;
    localparam logic [1:0] C_LEFT   = 2'b10;
    localparam logic [1:0] C_RED    = 2'b11;

    typedef enum logic [2:0] {
        GRN   = 3'd0,
        YEL_A = 3'd1,
        LFT   = 3'd2,
        YEL_B = 3'd3
`ifdef TL_PED_EN
        , WALK = 3'd4
`endif
    } phase_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Per-phase cycle counter with the terminal compares used by the phase FSM.
// The WALK_CYC terminal compare exists only when TL_PED_EN is defined.
module tl_phase_timer
    import tl_pkg::*;
#(
    parameter int unsigned MIN_GRN_CYC = 4,
    parameter int unsigned MAX_GRN_CYC = 16,
    parameter int unsigned YEL_CYC     = 2,
    parameter int unsigned WALK_CYC    = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic min_done_c,
    output logic max_hit_c,
`ifdef TL_PED_EN
    output logic walk_done_c,
`endif
    output logic yel_done_c
);

    localparam int unsigned CNT_MAX = max_u(max_u(MIN_GRN_CYC, MAX_GRN_CYC),
                                            max_u(YEL_CYC, WALK_CYC));
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // Saturate so an unlimited green keeps its minimum-time flag asserted.
    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (cnt != '1) begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    assign min_done_c  = (cnt >= CW'(MIN_GRN_CYC - 1));
    assign max_hit_c   = (MAX_GRN_CYC != 0) && (cnt == CW'(MAX_GRN_CYC - 1));
    assign yel_done_c  = (cnt == CW'(YEL_CYC - 1));
`ifdef TL_PED_EN
    assign walk_done_c = (cnt == CW'(WALK_CYC - 1));
`endif

endmodule

// File: rtl/tl_cntr_multi.sv
// Round-robin traffic light controller: GRN -> YEL_A -> [LFT -> YEL_B] per approach.
// Defining TL_PED_EN adds ped_req/walk and an all-red WALK phase at approach boundaries.
module tl_cntr_multi
    import tl_pkg::*;
#(
    parameter int unsigned N_APPR      = 2,
    parameter int unsigned MIN_GRN_CYC = 4,
    parameter int unsigned MAX_GRN_CYC = 16,
    parameter int unsigned YEL_CYC     = 2,
    parameter int unsigned WALK_CYC    = 3
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic [N_APPR-1:0]                             T,
    input  logic [N_APPR-1:0]                             TL,
`ifdef TL_PED_EN
    input  logic                                          ped_req,
    output logic                                          walk,
`endif
    output logic [2*N_APPR-1:0]                           L,
    output logic [((N_APPR > 2) ? $clog2(N_APPR) : 1)-1:0] idx
);

    localparam int unsigned IW = (N_APPR > 2) ? $clog2(N_APPR) : 1;
    localparam int unsigned LW = 2 * N_APPR;
    localparam logic [LW-1:0] L_RST = {{(N_APPR - 1){C_RED}}, C_GREEN};

    phase_t        state;
    phase_t        state_nxt;
    logic [IW-1:0] idx_nxt;
    logic [IW-1:0] idx_inc;
    logic [LW-1:0] l_nxt;
    logic          boundary;
    logic          min_done;
    logic          max_hit;
    logic          yel_done;
`ifdef TL_PED_EN
    logic          walk_done;
    logic          pend;
    logic          pend_nxt;
`endif

    tl_phase_timer #(
        .MIN_GRN_CYC (MIN_GRN_CYC),
        .MAX_GRN_CYC (MAX_GRN_CYC),
        .YEL_CYC     (YEL_CYC),
        .WALK_CYC    (WALK_CYC)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .clr         (state_nxt != state),
        .min_done_c  (min_done),
        .max_hit_c   (max_hit),
`ifdef TL_PED_EN
        .walk_done_c (walk_done),
`endif
        .yel_done_c  (yel_done)
    );

    assign idx_inc = (idx == IW'(N_APPR - 1)) ? '0 : idx + IW'(1);

    // Next-state logic; sensors only matter on the exit-decision cycle.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        boundary  = 1'b0;
`ifdef TL_PED_EN
        pend_nxt  = pend | ped_req;
`endif
        case (state)
            GRN: begin
                if (min_done && (!T[idx] || max_hit)) begin
                    state_nxt = YEL_A;
                end
            end
            YEL_A: begin
                if (yel_done) begin
                    if (TL[idx]) begin
                        state_nxt = LFT;
                    end else begin
                        boundary = 1'b1;
                    end
                end
            end
            LFT: begin
                if (min_done && (!TL[idx] || max_hit)) begin
                    state_nxt = YEL_B;
                end
            end
            YEL_B: begin
                if (yel_done) begin
                    boundary = 1'b1;
                end
            end
`ifdef TL_PED_EN
            WALK: begin
                if (walk_done) begin
                    state_nxt = GRN;
                    idx_nxt   = idx_inc;
                end
            end
`endif
            default: begin
                state_nxt = GRN;
            end
        endcase

        if (boundary) begin
`ifdef TL_PED_EN
            // A request arriving on the entry cycle is served by this walk, not re-latched.
            if (pend || ped_req) begin
                state_nxt = WALK;
                pend_nxt  = 1'b0;
            end else begin
                state_nxt = GRN;
                idx_nxt   = idx_inc;
            end
`else
            state_nxt = GRN;
            idx_nxt   = idx_inc;
`endif
        end
    end

    // Lamp decode of the upcoming state so L is a registered Moore output.
    always_comb begin
        l_nxt = {N_APPR{C_RED}};
        for (int unsigned i = 0; i < N_APPR; i++) begin
            if (idx_nxt == IW'(i)) begin
                case (state_nxt)
                    GRN:          l_nxt[2*i +: 2] = C_GREEN;
                    YEL_A, YEL_B: l_nxt[2*i +: 2] = C_YELLOW;
                    LFT:          l_nxt[2*i +: 2] = C_LEFT;
                    default:      l_nxt[2*i +: 2] = C_RED;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= GRN;
            idx   <= '0;
            L     <= L_RST;
`ifdef TL_PED_EN
            pend  <= 1'b0;
            walk  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            L     <= l_nxt;
`ifdef TL_PED_EN
            pend  <= pend_nxt;
            walk  <= (state_nxt == WALK);
`endif
        end
    end

endmodule

// File: tb/tb_tl_cntr_multi.sv
// Testbench for tl_cntr_multi (N_APPR=3, MIN=4, MAX=10, YEL=2, WALK=3).
// Pedestrian scenarios run when TL_PED_EN is defined.
module tb_tl_cntr_multi;

    localparam int N    = 3;
    localparam int MIN  = 4;
    localparam int MAX  = 10;
    localparam int YEL  = 2;
    localparam int WLK  = 3;

    localparam logic [1:0] COL_G = 2'b00;
    localparam logic [1:0] COL_Y = 2'b01;
    localparam logic [1:0] COL_L = 2'b10;

    localparam int PH_G  = 0;
    localparam int PH_YA = 1;
    localparam int PH_L  = 2;
    localparam int PH_YB = 3;
    localparam int PH_W  = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] T;
    logic [2:0] TL;
    logic       ped_req;
    logic [5:0] L;
    logic [1:0] idx;
`ifdef TL_PED_EN
    logic       walk;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase name, active approach, cycles already spent in the phase.
    int m_phase;
    int m_app;
    int m_age;
    bit m_pend;

    always #5 clk = ~clk;

    tl_cntr_multi #(
        .N_APPR      (N),
        .MIN_GRN_CYC (MIN),
        .MAX_GRN_CYC (MAX),
        .YEL_CYC     (YEL),
        .WALK_CYC    (WLK)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .T       (T),
        .TL      (TL),
`ifdef TL_PED_EN
        .ped_req (ped_req),
        .walk    (walk),
`endif
        .L       (L),
        .idx     (idx)
    );

    function automatic logic [5:0] mk_l(input int app, input logic [1:0] col);
        logic [5:0] v;
        v = '1;
        v[2*app +: 2] = col;
        return v;
    endfunction

    function automatic logic [5:0] model_l();
        case (m_phase)
            PH_G:         return mk_l(m_app, COL_G);
            PH_YA, PH_YB: return mk_l(m_app, COL_Y);
            PH_L:         return mk_l(m_app, COL_L);
            default:      return 6'b111111;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = PH_G;
        m_app   = 0;
        m_age   = 0;
        m_pend  = 0;
    endtask

    // Advance the model by one clock using the sensor values seen at that edge.
    task automatic model_step(input logic [2:0] t, input logic [2:0] tl, input logic pr);
        int done;
        int nxt;
        bit boundary;
        done     = m_age + 1;
        nxt      = m_phase;
        boundary = 0;
        case (m_phase)
            PH_G:  if (done >= MIN && (t[m_app] == 1'b0 || done == MAX)) nxt = PH_YA;
            PH_YA: if (done == YEL) begin
                       if (tl[m_app]) nxt = PH_L;
                       else boundary = 1;
                   end
            PH_L:  if (done >= MIN && (tl[m_app] == 1'b0 || done == MAX)) nxt = PH_YB;
            PH_YB: if (done == YEL) boundary = 1;
            PH_W:  if (done == WLK) begin
                       nxt   = PH_G;
                       m_app = (m_app + 1) % N;
                   end
            default: nxt = PH_G;
        endcase
        if (boundary) begin
            if (m_pend || pr) begin
                nxt    = PH_W;
                m_pend = 0;
            end else begin
                nxt   = PH_G;
                m_app = (m_app + 1) % N;
            end
        end else begin
            m_pend = m_pend | pr;
        end
        m_age   = (nxt != m_phase) ? 0 : done;
        m_phase = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(T, TL, ped_req);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        T       = '0;
        TL      = '0;
        ped_req = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        T       = 3'b111;
        TL      = 3'b111;
        ped_req = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (L !== 6'b111100) begin
            n_errors++;
            $display("FAIL reset_L L=%b expected %b", L, 6'b111100);
        end
        n_checks++;
        if (idx !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_idx idx=%0d expected 0", idx);
        end
`ifdef TL_PED_EN
        n_checks++;
        if (walk !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_walk walk=%b expected 0", walk);
        end
`endif
    endtask

    // Idle sensors: 4 green, 2 yellow, left skipped, next approach green at cycle 6.
    task automatic test_skip_left();
        logic [5:0] exp_l;
        apply_reset();
        for (int k = 0; k <= 6; k++) begin
            if (k < 4)      exp_l = mk_l(0, COL_G);
            else if (k < 6) exp_l = mk_l(0, COL_Y);
            else            exp_l = mk_l(1, COL_G);
            n_checks++;
            if (L !== exp_l || idx !== ((k < 6) ? 2'd0 : 2'd1)) begin
                n_errors++;
                $display("FAIL skip_left k=%0d L=%b idx=%0d expected L=%b", k, L, idx, exp_l);
            end
            tick();
        end
    endtask

    // Continuous demand on approach 0: green capped at MAX cycles.
    task automatic test_max_green();
        logic [5:0] exp_l;
        apply_reset();
        T = 3'b001;
        for (int k = 0; k <= 11; k++) begin
            if (k < 10) exp_l = mk_l(0, COL_G);
            else        exp_l = mk_l(0, COL_Y);
            n_checks++;
            if (L !== exp_l) begin
                n_errors++;
                $display("FAIL max_green k=%0d L=%b expected %b", k, L, exp_l);
            end
            tick();
        end
    endtask

    // Left on approach 0 for 6 cycles, then left on approach 2 and wrap to approach 0.
    task automatic test_left_and_wrap();
        logic [5:0] exp_l;
        int         exp_i;
        apply_reset();
        for (int k = 0; k <= 32; k++) begin
            if (k < 11)      TL = 3'b001;
            else if (k < 26) TL = 3'b100;
            else             TL = 3'b000;
            if (k < 4)       begin exp_i = 0; exp_l = mk_l(0, COL_G); end
            else if (k < 6)  begin exp_i = 0; exp_l = mk_l(0, COL_Y); end
            else if (k < 12) begin exp_i = 0; exp_l = mk_l(0, COL_L); end
            else if (k < 14) begin exp_i = 0; exp_l = mk_l(0, COL_Y); end
            else if (k < 18) begin exp_i = 1; exp_l = mk_l(1, COL_G); end
            else if (k < 20) begin exp_i = 1; exp_l = mk_l(1, COL_Y); end
            else if (k < 24) begin exp_i = 2; exp_l = mk_l(2, COL_G); end
            else if (k < 26) begin exp_i = 2; exp_l = mk_l(2, COL_Y); end
            else if (k < 30) begin exp_i = 2; exp_l = mk_l(2, COL_L); end
            else if (k < 32) begin exp_i = 2; exp_l = mk_l(2, COL_Y); end
            else             begin exp_i = 0; exp_l = mk_l(0, COL_G); end
            n_checks++;
            if (L !== exp_l || idx !== 2'(exp_i)) begin
                n_errors++;
                $display("FAIL left_wrap k=%0d L=%b idx=%0d expected L=%b idx=%0d",
                         k, L, idx, exp_l, exp_i);
            end
            tick();
        end
    endtask

    // Reset pulsed between clock edges while approach 1 is in LEFT.
    task automatic test_reset_mid_left();
        apply_reset();
        TL = 3'b010;
        repeat (13) tick();
        n_checks++;
        if (L !== 6'b111011 || idx !== 2'd1) begin
            n_errors++;
            $display("FAIL pre_reset_left L=%b idx=%0d expected L=111011 idx=1", L, idx);
        end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (L !== 6'b111100 || idx !== 2'd0) begin
            n_errors++;
            $display("FAIL async_reset L=%b idx=%0d expected L=111100 idx=0", L, idx);
        end
        @(negedge clk);
        reset_n = 1'b1;
        TL      = 3'b000;
        #1;
        for (int k = 0; k <= 4; k++) begin
            n_checks++;
            if (L !== ((k < 4) ? 6'b111100 : 6'b111101)) begin
                n_errors++;
                $display("FAIL post_reset k=%0d L=%b", k, L);
            end
            tick();
        end
    endtask

`ifdef TL_PED_EN
    // Pedestrian pulse during approach 0 green: 3-cycle all-red walk after its yellow.
    task automatic test_ped();
        logic [5:0] exp_l;
        logic       exp_w;
        apply_reset();
        for (int k = 0; k <= 10; k++) begin
            ped_req = (k == 1);
            if (k < 4)      begin exp_l = mk_l(0, COL_G); exp_w = 1'b0; end
            else if (k < 6) begin exp_l = mk_l(0, COL_Y); exp_w = 1'b0; end
            else if (k < 9) begin exp_l = 6'b111111;      exp_w = 1'b1; end
            else            begin exp_l = mk_l(1, COL_G); exp_w = 1'b0; end
            n_checks++;
            if (L !== exp_l || walk !== exp_w) begin
                n_errors++;
                $display("FAIL ped_walk k=%0d L=%b walk=%b expected L=%b walk=%b",
                         k, L, walk, exp_l, exp_w);
            end
            tick();
        end
        ped_req = 1'b0;
    endtask
`endif

    // Random sensors (and sparse pedestrian pulses) against the reference model.
    task automatic test_random();
        logic exp_w;
        logic act_w;
        apply_reset();
        for (int k = 0; k < 600; k++) begin
            T  = 3'($urandom_range(0, 7) | $urandom_range(0, 7));
            TL = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
`ifdef TL_PED_EN
            ped_req = ($urandom_range(0, 19) == 0);
            act_w   = walk;
`else
            ped_req = 1'b0;
            act_w   = 1'b0;
`endif
            exp_w = (m_phase == PH_W);
            n_checks++;
            if (L !== model_l() || idx !== 2'(m_app) || act_w !== exp_w) begin
                n_errors++;
                $display("FAIL random k=%0d L=%b idx=%0d walk=%b expected L=%b idx=%0d walk=%b",
                         k, L, idx, act_w, model_l(), m_app, exp_w);
            end
            tick();
        end
        ped_req = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        T       = '0;
        TL      = '0;
        ped_req = 1'b0;
        model_reset();
        test_reset();
        test_skip_left();
        test_max_green();
        test_left_and_wrap();
        test_reset_mid_left();
`ifdef TL_PED_EN
        test_ped();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tl_cntr_multi.md
TL_CNTR_MULTI -- requirements
Module: tl_cntr_multi

Interface
REQ-001 SHALL provide parameter N_APPR, default 2, number of approaches (range 2..4).
REQ-002 SHALL provide parameter MIN_GRN_CYC, default 4, minimum cycles in GREEN or LEFT (>=1).
REQ-003 SHALL provide parameter MAX_GRN_CYC, default 16, maximum cycles in GREEN or LEFT (0 = unlimited; else >=MIN_GRN_CYC).
REQ-004 SHALL provide parameter YEL_CYC, default 2, cycles per YELLOW interval (>=1).
REQ-005 SHALL provide parameter WALK_CYC, default 3, cycles of the pedestrian phase (used only with TL_PED_EN).
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset_n, input, 1; one clock; reset is asynchronous and active-low.
REQ-008 SHALL have port T, input, N_APPR, through-traffic sensor per approach (1 = cars waiting).
REQ-009 SHALL have port TL, input, N_APPR, left-turn sensor per approach.
REQ-010 SHALL have port L, output, 2*N_APPR, light colour of approach i on L[2i+1:2i].
REQ-011 SHALL have port idx, output, max(1,$clog2(N_APPR)), index of the active approach.
REQ-012 SHALL, with TL_PED_EN only, have port ped_req (input, 1, pedestrian request pulse) and port walk (output, 1, walk lamp).

Function
REQ-013 SHALL encode colours GREEN=00, YELLOW=01, LEFT=10, RED=11.
REQ-014 SHALL run per-approach phase FSM GRN -> YEL_A -> LFT -> YEL_B, round-robin over idx 0..N_APPR-1, wrapping from N_APPR-1 to 0.
REQ-015 SHALL drive the active approach GREEN in GRN, YELLOW in YEL_A/YEL_B, LEFT in LFT; every other approach SHALL be RED.
REQ-016 SHALL keep a cycle counter cnt cleared on each state entry; outputs are Moore, decoded from state and idx only.
REQ-017 SHALL leave GRN when cnt >= MIN_GRN_CYC-1 and either T[idx]=0 or (MAX_GRN_CYC!=0 and cnt = MAX_GRN_CYC-1).
REQ-018 SHALL leave LFT by the same rule as REQ-017 with TL[idx] in place of T[idx].
REQ-019 SHALL leave YEL_A/YEL_B when cnt = YEL_CYC-1.
REQ-020 SHALL, at exit of YEL_A, go to LFT if TL[idx]=1, else skip to GRN of the next approach.
REQ-021 SHALL, at exit of YEL_B, go to GRN of the next approach.
REQ-022 SHALL sample sensors only on the exit-decision cycle; sensor changes elsewhere have no effect.

Reset
REQ-023 SHALL, while reset_n=0, force state GRN, idx=0, cnt=0; L = approach 0 GREEN, all others RED; walk=0; pending ped request cleared.
REQ-024 SHALL, on reset assertion mid-phase, apply REQ-023 immediately, with no yellow interval.

Configuration
REQ-025 SHALL, when TL_PED_EN is defined, latch ped_req into a pending flag and, at the next approach boundary (exit of YEL_A with skip, or of YEL_B), insert state WALK: all approaches RED, walk=1, for WALK_CYC cycles, then GRN of the next approach.
REQ-026 SHALL clear the pending flag on WALK entry; ped_req asserted in that same cycle SHALL be consumed, not re-latched.
REQ-027 SHALL, when TL_PED_EN is undefined, omit ped_req, walk, the pending flag and the WALK state entirely.

Structure
REQ-028 SHALL place colour constants and the phase-state enum in shared package tl_pkg.
REQ-029 SHALL implement cnt and its terminal compares in sub-module tl_phase_timer (clear, count, width from the largest parameter).

Verification
REQ-030 N_APPR=3, MIN=4, MAX=10, YEL=2: hold reset_n=0 -> L=6'b111100, idx=0.
REQ-031 T=0, TL=0: approach 0 GREEN 4 cycles, YELLOW 2, then idx=1 GREEN at cycle 6 (LEFT skipped).
REQ-032 T[0]=1 held: GREEN exactly 10 cycles, then YELLOW.
REQ-033 TL[0]=1 held for 6 LFT cycles: LEFT lasts 6 cycles, YELLOW 2, then idx=1 GREEN; at idx=2 YEL_B exit, idx wraps to 0.
REQ-034 reset_n pulsed low during LFT of idx=1: L=6'b111100 asynchronously, with no yellow.
REQ-035 TL_PED_EN, WALK_CYC=3: ped_req pulse during idx=0 GRN -> after idx=0's final yellow, L all RED with walk=1 for 3 cycles, then idx=1 GREEN.
